// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants for the VGA raster timing generator: default 640x480@60
//   geometry, the coordinate width, and the axis state encoding used by both
//   the horizontal and the vertical axis state machines.
package vga_pkg;

   // Width of o_x / o_y and of every per-axis counter.
   localparam int COORD_W   = 12;
   localparam int COORD_MAX = (1 << COORD_W) - 1;

   // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical).
   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   // Segment order along one axis; BACK is followed by ACTIVE again.
   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FRONT  = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BACK   = 2'd3
   } axis_state_t;

endpackage

// File: rtl/vga_axis.sv
// vga_axis
//   One raster axis: walks ACTIVE -> FRONT -> SYNC -> BACK, advancing one
//   position per i_adv. Position, sync and blank are registered together so
//   they always change on the same clock edge.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_adv    advance by one position on this clock edge
//   count    position along the axis, 0..TOTAL-1
//   sync     sync level (SYNC_POL while in the SYNC segment)
//   blank    high outside the ACTIVE segment
//   wrap     combinational: count is at TOTAL-1, next advance returns to 0
module vga_axis
   import vga_pkg::*;
#(
   parameter int ACTIVE   = DEF_H_ACTIVE,
   parameter int FRONT    = DEF_H_FRONT,
   parameter int SYNC     = DEF_H_SYNC,
   parameter int BACK     = DEF_H_BACK,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_adv,
   output logic [COORD_W-1:0] count,
   output logic               sync,
   output logic               blank,
   output logic               wrap
);

   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

   if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_len
      $error("vga_axis: every segment length must be at least 1");
   end
   if (TOTAL > COORD_MAX) begin : g_bad_total
      $error("vga_axis: axis total does not fit the coordinate width");
   end

   localparam logic [COORD_W-1:0] LAST_ACTIVE = COORD_W'(ACTIVE - 1);
   localparam logic [COORD_W-1:0] LAST_FRONT  = COORD_W'(FRONT - 1);
   localparam logic [COORD_W-1:0] LAST_SYNC   = COORD_W'(SYNC - 1);
   localparam logic [COORD_W-1:0] LAST_BACK   = COORD_W'(BACK - 1);

   axis_state_t        state, state_next, seg_next;
   logic [COORD_W-1:0] run, run_next;
   logic [COORD_W-1:0] count_next;
   logic [COORD_W-1:0] seg_last;
   logic               sync_next, blank_next;

   // NOTE: every signal gets a default before any branch so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_next = state;
      run_next   = run;
      count_next = count;
      seg_last   = LAST_ACTIVE;
      seg_next   = ST_FRONT;

      unique case (state)
         ST_ACTIVE: begin seg_last = LAST_ACTIVE; seg_next = ST_FRONT;  end
         ST_FRONT:  begin seg_last = LAST_FRONT;  seg_next = ST_SYNC;   end
         ST_SYNC:   begin seg_last = LAST_SYNC;   seg_next = ST_BACK;   end
         ST_BACK:   begin seg_last = LAST_BACK;   seg_next = ST_ACTIVE; end
      endcase

      // Last position of BACK is the last position of the whole axis.
      wrap = (state == ST_BACK) && (run == seg_last);

      if (i_adv) begin
         count_next = wrap ? '0 : count + 1'b1;
         if (run == seg_last) begin
            run_next   = '0;
            state_next = seg_next;
         end else begin
            run_next = run + 1'b1;
         end
      end

      // Decoded from the next state so the flags register alongside count.
      blank_next = (state_next != ST_ACTIVE);
      sync_next  = (state_next == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values and update order inside the block does not matter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_ACTIVE;
         run   <= '0;
         count <= '0;
         sync  <= ~SYNC_POL;
         blank <= 1'b0;
      end else begin
         state <= state_next;
         run   <= run_next;
         count <= count_next;
         sync  <= sync_next;
         blank <= blank_next;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// vga_timing
//   Free-running VGA raster timing generator. A clock divider produces the
//   pixel-rate enable; a horizontal and a vertical vga_axis produce the
//   coordinates, sync and blanking. Consumers qualify everything with o_pix_en.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   o_pix_en       one-i_clk pulse per pixel period
//   o_hsync        horizontal sync, asserted level SYNC_POL
//   o_vsync        vertical sync, asserted level SYNC_POL
//   o_hblank       high outside the horizontal active region
//   o_vblank       high outside the vertical active region
//   o_active       ~o_hblank & ~o_vblank
//   o_x, o_y       raw raster position
//   o_line_start   with o_pix_en, while o_x is 0
//   o_frame_start  with o_pix_en, while o_x and o_y are both 0
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   output logic               o_pix_en,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_hblank,
   output logic               o_vblank,
   output logic               o_active,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic               o_line_start,
   output logic               o_frame_start
);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing: CLK_DIV must be at least 1");
   end

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;
   logic             tick;
   logic             h_wrap, v_wrap, v_adv;
   logic             x_next_zero, y_next_zero;

   assign tick  = (div == DIV_LAST);
   assign v_adv = o_pix_en & h_wrap;

   // The axes move on the edge that samples o_pix_en high. The line/frame
   // pulses are registered on the tick edge, so they must look at the
   // position the axes will hold after that same edge: with CLK_DIV > 1 the
   // axes are idle there, with CLK_DIV == 1 they are advancing.
   assign x_next_zero = o_pix_en ? h_wrap : (o_x == '0);
   assign y_next_zero = v_adv    ? v_wrap : (o_y == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div           <= '0;
         o_pix_en      <= 1'b0;
         o_line_start  <= 1'b0;
         o_frame_start <= 1'b0;
      end else begin
         div           <= tick ? '0 : div + 1'b1;
         o_pix_en      <= tick;
         o_line_start  <= tick & x_next_zero;
         o_frame_start <= tick & x_next_zero & y_next_zero;
      end
   end

   vga_axis #(
      .ACTIVE   (H_ACTIVE),
      .FRONT    (H_FRONT),
      .SYNC     (H_SYNC),
      .BACK     (H_BACK),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_adv   (o_pix_en),
      .count   (o_x),
      .sync    (o_hsync),
      .blank   (o_hblank),
      .wrap    (h_wrap)
   );

   vga_axis #(
      .ACTIVE   (V_ACTIVE),
      .FRONT    (V_FRONT),
      .SYNC     (V_SYNC),
      .BACK     (V_BACK),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_adv   (v_adv),
      .count   (o_y),
      .sync    (o_vsync),
      .blank   (o_vblank),
      .wrap    (v_wrap)
   );

   assign o_active = ~o_hblank & ~o_vblank;

endmodule
